// File: rtl/vedic_mac_pkg.sv
// Shared types and default widths for the Vedic multiply-accumulate slice.
package vedic_mac_pkg;

  // Default datapath widths
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned CNT_W  = 4;

  // Accumulator control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage : vedic_mac_pkg

// File: rtl/vedic_mac_accum_if.sv
// Control, product-input and result-output bundle of the MAC accumulator.
interface vedic_mac_accum_if #(
  parameter int unsigned PROD_W = vedic_mac_pkg::PROD_W,
  parameter int unsigned ACC_W  = vedic_mac_pkg::ACC_W,
  parameter int unsigned CNT_W  = vedic_mac_pkg::CNT_W
) ();

  // Run control
  logic              start;
  logic [CNT_W-1:0]  n_terms;
  logic              busy;

  // Product stream from the multiplier
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;

  // Result towards the consumer
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              ovf;

  // Driver of commands/products and sink of results
  modport master (
    output start, n_terms, prod_valid, prod, acc_ready,
    input  busy, prod_ready, acc_out, acc_valid, ovf
  );

  // The accumulator itself
  modport slave (
    input  start, n_terms, prod_valid, prod, acc_ready,
    output busy, prod_ready, acc_out, acc_valid, ovf
  );

endinterface : vedic_mac_accum_if

// File: rtl/vedic_sat_add.sv
// Combinational saturating adder: ACC_W accumulator plus zero-extended product.
module vedic_sat_add #(
  parameter int unsigned ACC_W  = vedic_mac_pkg::ACC_W,
  parameter int unsigned PROD_W = vedic_mac_pkg::PROD_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat_flag
);

  localparam int unsigned WIDE_W = ACC_W + 1;

  logic [WIDE_W-1:0] wide_sum;

  // One extra bit catches the carry-out; on carry the result pins to all ones
  always_comb begin
    wide_sum = WIDE_W'(a) + WIDE_W'(b);
    sat_flag = wide_sum[ACC_W];
    sum      = sat_flag ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
  end

endmodule : vedic_sat_add

// File: rtl/vedic_mac_accum.sv
// Accumulates a programmed number of unsigned products into a saturating sum
// and holds the result until the consumer accepts it.
module vedic_mac_accum #(
  parameter int unsigned PROD_W = vedic_mac_pkg::PROD_W,
  parameter int unsigned ACC_W  = vedic_mac_pkg::ACC_W,
  parameter int unsigned CNT_W  = vedic_mac_pkg::CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  vedic_mac_accum_if.slave  bus
);

  import vedic_mac_pkg::*;

  state_t             state_q, state_nxt;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic               ovf_q, ovf_nxt;
  logic [CNT_W-1:0]   count_q, count_nxt;

  // Handshake/status flops are loaded from the next state so they line up
  // exactly with the state they describe, without any input-to-output path.
  logic               prod_ready_q;
  logic               acc_valid_q;
  logic               busy_q;

  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;
  logic               xfer;

  // Saturating add of the incoming product onto the running sum
  vedic_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .a        (acc_q),
    .b        (bus.prod),
    .sum      (add_sum),
    .sat_flag (add_sat)
  );

  // A product moves only while accumulating; prod_ready is a pure state decode
  assign xfer = (state_q == ACCUM) && bus.prod_valid;

  // Next-state, accumulator, overflow and term-count logic
  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    ovf_nxt   = ovf_q;
    count_nxt = count_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          ovf_nxt = 1'b0;
          if (bus.n_terms != '0) begin
            count_nxt = bus.n_terms;
            state_nxt = ACCUM;
          end else begin
            state_nxt = HOLD;
          end
        end
      end

      ACCUM: begin
        if (xfer) begin
          acc_nxt   = add_sum;
          ovf_nxt   = ovf_q | add_sat;
          count_nxt = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.acc_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      acc_q        <= acc_nxt;
      ovf_q        <= ovf_nxt;
      count_q      <= count_nxt;
      prod_ready_q <= (state_nxt == ACCUM);
      acc_valid_q  <= (state_nxt == HOLD);
      busy_q       <= (state_nxt != IDLE);
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.busy       = busy_q;
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;

endmodule : vedic_mac_accum

// File: tb/tb_vedic_mac_accum.sv
// Scenario bench for vedic_mac_accum with a result scoreboard.
module tb_vedic_mac_accum;

  localparam int unsigned ACC_W   = 18;
  localparam longint      ACC_MAX = 262143;
  localparam int          GUARD   = 60;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t   sb[$];
  longint model_acc;
  logic   model_ovf;

  vedic_mac_accum_if bus ();

  vedic_mac_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference accumulation: plain wide add, clamped at the accumulator max
  task automatic model_clear();
    model_acc = 0;
    model_ovf = 1'b0;
  endtask

  task automatic model_add(input int unsigned p);
    model_acc = model_acc + longint'(p);
    if (model_acc > ACC_MAX) begin
      model_acc = ACC_MAX;
      model_ovf = 1'b1;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.acc = ACC_W'(model_acc);
    e.ovf = model_ovf;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; returns #1 after the accepting edge
  task automatic drive_start(input int n);
    bus.start   = 1'b1;
    bus.n_terms = 4'(n);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    model_clear();
  endtask

  // Offer one product and hold it until it transfers
  task automatic send_prod(input int unsigned p);
    int g;
    bus.prod_valid = 1'b1;
    bus.prod       = 16'(p);
    g = 0;
    while (bus.prod_ready !== 1'b1 && g < GUARD) begin
      @(posedge clk); #1;
      g++;
    end
    total++;
    if (bus.prod_ready !== 1'b1) begin
      bad++;
      $display("FAIL prod_ready_timeout got=%b want=1", bus.prod_ready);
    end
    @(posedge clk); #1;
    bus.prod_valid = 1'b0;
    model_add(p);
  endtask

  // Wait for a result, check it against the scoreboard, stall, then accept
  task automatic collect_result(input int stall);
    exp_t e;
    int   g;
    g = 0;
    while (bus.acc_valid !== 1'b1 && g < GUARD) begin
      @(posedge clk); #1;
      g++;
    end
    total++;
    if (bus.acc_valid !== 1'b1) begin
      bad++;
      $display("FAIL acc_valid_timeout got=%b want=1", bus.acc_valid);
    end
    e.acc = '0;
    e.ovf = 1'b0;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%0d want>0", sb.size());
    end else begin
      e = sb.pop_front();
    end
    total++;
    if (bus.acc_out !== e.acc) begin
      bad++;
      $display("FAIL acc_out got=%0d want=%0d", bus.acc_out, e.acc);
    end
    total++;
    if (bus.ovf !== e.ovf) begin
      bad++;
      $display("FAIL ovf got=%b want=%b", bus.ovf, e.ovf);
    end
    bus.acc_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.acc_valid !== 1'b1 || bus.acc_out !== e.acc) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got valid=%b acc=%0d want valid=1 acc=%0d",
                 i, bus.acc_valid, bus.acc_out, e.acc);
      end
    end
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    bus.acc_ready = 1'b0;
    total++;
    if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL release got valid=%b busy=%b want valid=0 busy=0",
               bus.acc_valid, bus.busy);
    end
    total++;
    if (bus.acc_out !== e.acc || bus.ovf !== e.ovf) begin
      bad++;
      $display("FAIL idle_keep got acc=%0d ovf=%b want acc=%0d ovf=%b",
               bus.acc_out, bus.ovf, e.acc, e.ovf);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.n_terms    = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.acc_ready  = 1'b0;
    #3;
    total++;
    if (bus.acc_out !== '0 || bus.acc_valid !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got acc=%0d v=%b ovf=%b busy=%b rdy=%b want all 0",
               bus.acc_out, bus.acc_valid, bus.ovf, bus.busy, bus.prod_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL after_release got busy=%b rdy=%b want 0 0", bus.busy, bus.prod_ready);
    end
  endtask

  task automatic test_normal();
    drive_start(3);
    total++;
    if (bus.prod_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL accum_entry got rdy=%b busy=%b want 1 1", bus.prod_ready, bus.busy);
    end
    send_prod(65025);
    send_prod(65025);
    total++;
    if (bus.acc_valid !== 1'b0 || bus.acc_out !== 18'(model_acc)) begin
      bad++;
      $display("FAIL partial got v=%b acc=%0d want v=0 acc=%0d",
               bus.acc_valid, bus.acc_out, model_acc);
    end
    send_prod(65025);
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== 18'h2FA03) begin
      bad++;
      $display("FAIL normal_latency got v=%b acc=%0d want v=1 acc=%0d",
               bus.acc_valid, bus.acc_out, 195075);
    end
    push_expected();
    collect_result(0);
  endtask

  task automatic test_saturation();
    drive_start(5);
    for (int i = 0; i < 5; i++) send_prod(65025);
    total++;
    if (bus.acc_out !== 18'h3FFFF || bus.ovf !== 1'b1) begin
      bad++;
      $display("FAIL saturate got acc=%0d ovf=%b want acc=%0d ovf=1",
               bus.acc_out, bus.ovf, 262143);
    end
    push_expected();
    collect_result(1);
  endtask

  task automatic test_bubbles_backpressure();
    drive_start(2);
    total++;
    if (bus.ovf !== 1'b0 || bus.acc_out !== '0) begin
      bad++;
      $display("FAIL start_clears got acc=%0d ovf=%b want 0 0", bus.acc_out, bus.ovf);
    end
    send_prod(100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b1 || bus.acc_out !== 18'd100) begin
        bad++;
        $display("FAIL bubble cyc=%0d got v=%b busy=%b acc=%0d want v=0 busy=1 acc=100",
                 i, bus.acc_valid, bus.busy, bus.acc_out);
      end
    end
    send_prod(200);
    push_expected();
    collect_result(4);
  endtask

  task automatic test_zero_terms();
    drive_start(0);
    bus.prod_valid = 1'b1;
    bus.prod       = 16'd5;
    total++;
    if (bus.acc_valid !== 1'b1 || bus.acc_out !== '0 || bus.prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_terms got v=%b acc=%0d rdy=%b want v=1 acc=0 rdy=0",
               bus.acc_valid, bus.acc_out, bus.prod_ready);
    end
    push_expected();
    collect_result(2);
    bus.prod_valid = 1'b0;
    total++;
    if (bus.prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_idle_rdy got=%b want=0", bus.prod_ready);
    end
  endtask

  task automatic test_start_while_busy();
    drive_start(4);
    send_prod(11);
    send_prod(22);
    bus.start   = 1'b1;
    bus.n_terms = 4'd7;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    total++;
    if (bus.acc_out !== 18'd33 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start got acc=%0d busy=%b want acc=33 busy=1", bus.acc_out, bus.busy);
    end
    send_prod(33);
    total++;
    if (bus.acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_early_valid got=%b want=0", bus.acc_valid);
    end
    send_prod(44);
    push_expected();
    collect_result(0);
  endtask

  task automatic test_async_reset();
    drive_start(4);
    send_prod(500);
    send_prod(600);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.acc_out !== '0 || bus.acc_valid !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.busy !== 1'b0 || bus.prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got acc=%0d v=%b ovf=%b busy=%b rdy=%b want all 0",
               bus.acc_out, bus.acc_valid, bus.ovf, bus.busy, bus.prod_ready);
    end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_start(1);
    send_prod(9);
    push_expected();
    collect_result(0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(15, 1));
      drive_start(n);
      for (int k = 0; k < n; k++) begin
        send_prod($urandom_range(65025, 0));
        if ($urandom_range(3, 0) == 0) begin
          @(posedge clk); #1;
        end
      end
      push_expected();
      collect_result(int'($urandom_range(2, 0)));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    test_reset();
    test_normal();
    test_saturation();
    test_bubbles_backpressure();
    test_zero_terms();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vedic_mac_accum
